// File: rtl/inv_cipher_core.sv
// inv_cipher_core: iterative AES-128 decryption, one inverse round per clock.
// Optional INV_CIPHER_ROUND_TAP_EN exposes the state register and round counter.
// Purpose: ciphertext + expanded key schedule in, plaintext + out_valid out.
// Latency: out_valid rises 10 clocks after the edge that accepts start.
// Backpressure: none; start is only honoured in IDLE/DONE and dropped while busy.

module inv_shift_rows (
    input  logic [0:127] data_i,
    output logic [0:127] data_o
);
    // Row r is rotated right by r bytes; byte index is 4*column + row.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign data_o[8*(4*c+r) +: 8] = data_i[8*(4*((c+4-r)%4)+r) +: 8];
        end
    end
endmodule

module inv_sub_bytes (
    input  logic [0:127] data_i,
    output logic [0:127] data_o
);
    localparam logic [0:2047] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign data_o[8*i +: 8] = INV_SBOX[{data_i[8*i +: 8], 3'b000} +: 8];
    end
endmodule

module inv_mix_columns (
    input  logic [0:127] data_i,
    output logic [0:127] data_o
);
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by one of {09,0b,0d,0e} built from repeated doubling.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] a2, a4, a8;
        a2 = xt(a);
        a4 = xt(a2);
        a8 = xt(a4);
        return (k[3] ? a8 : 8'h00) ^ (k[2] ? a4 : 8'h00) ^
               (k[1] ? a2 : 8'h00) ^ (k[0] ? a  : 8'h00);
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = data_i[32*c      +: 8];
        assign a1 = data_i[32*c + 8  +: 8];
        assign a2 = data_i[32*c + 16 +: 8];
        assign a3 = data_i[32*c + 24 +: 8];
        assign data_o[32*c      +: 8] = gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9);
        assign data_o[32*c + 8  +: 8] = gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd);
        assign data_o[32*c + 16 +: 8] = gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb);
        assign data_o[32*c + 24 +: 8] = gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he);
    end
endmodule

module add_round_key (
    input  logic [0:127] data_i,
    input  logic [0:127] key_i,
    output logic [0:127] data_o
);
    assign data_o = data_i ^ key_i;
endmodule

module inv_cipher_core (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [0:127]   in,
    input  logic [0:1407]  words,
    output logic [0:127]   out,
    output logic           out_valid,
    output logic           busy
`ifdef INV_CIPHER_ROUND_TAP_EN
    ,
    output logic [0:127]   round_state,
    output logic [3:0]     round_idx
`endif
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    fsm_t         fsm_q;
    logic [0:127] state_q;
    logic [3:0]   rnd_q;
    logic [0:127] out_q;
    logic         out_valid_q;
    logic         busy_q;

    logic [0:127] rk;
    logic [0:127] isr_dat, isb_dat, ark_dat, imc_dat, init_dat;

    // Round key for the current counter value; rnd_q only spans 0..9 in ROUND.
    always_comb begin
        rk = words[0 +: 128];
        for (int k = 1; k <= 9; k++) begin
            if (rnd_q == 4'(k)) rk = words[128*k +: 128];
        end
    end

    add_round_key   u_ark_init (.data_i(in),      .key_i(words[1280 +: 128]), .data_o(init_dat));
    inv_shift_rows  u_isr      (.data_i(state_q), .data_o(isr_dat));
    inv_sub_bytes   u_isb      (.data_i(isr_dat), .data_o(isb_dat));
    add_round_key   u_ark      (.data_i(isb_dat), .key_i(rk),                 .data_o(ark_dat));
    inv_mix_columns u_imc      (.data_i(ark_dat), .data_o(imc_dat));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            rnd_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q     <= init_dat;
                        rnd_q       <= 4'd9;
                        fsm_q       <= ROUND;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                ROUND: begin
                    if (rnd_q == 4'd0) begin
                        out_q       <= ark_dat;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        fsm_q       <= DONE;
                    end else begin
                        state_q <= imc_dat;
                        rnd_q   <= rnd_q - 4'd1;
                    end
                end
                default: begin
                    fsm_q  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

`ifdef INV_CIPHER_ROUND_TAP_EN
    assign round_state = state_q;
    assign round_idx   = rnd_q;
`endif

endmodule

// File: tb/tb_inv_cipher_core.sv
// Bench for inv_cipher_core: FIPS-197 vectors, start rules, reset abort,
// and random loopback through a forward AES-128 model built here.
module tb_inv_cipher_core;
    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [0:127]   ct_in;
    logic [0:1407]  words;
    logic [0:127]   out;
    logic           out_valid;
    logic           busy;
`ifdef INV_CIPHER_ROUND_TAP_EN
    logic [0:127]   round_state;
    logic [3:0]     round_idx;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] sbox [256];

    inv_cipher_core dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in(ct_in), .words(words),
        .out(out), .out_valid(out_valid), .busy(busy)
`ifdef INV_CIPHER_ROUND_TAP_EN
        , .round_state(round_state), .round_idx(round_idx)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    // Forward S-box from first principles: GF inverse then affine map.
    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] p = 8'h01;
            logic [7:0] b;
            for (int k = 0; k < 254; k++) p = gmul(p, 8'(v));
            b = p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
            sbox[v] = b;
        end
    endtask

    function automatic logic [0:1407] expand(input logic [0:127] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        logic [0:1407] ks;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) ks[32*i +: 32] = w[i];
        return ks;
    endfunction

    function automatic logic [0:127] sub_shift(input logic [0:127] s);
        logic [0:127] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(4*c+r) +: 8] = sbox[s[8*(4*((c+r)%4)+r) +: 8]];
        return o;
    endfunction

    function automatic logic [0:127] mix(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8]; a1 = s[32*c+8 +: 8]; a2 = s[32*c+16 +: 8]; a3 = s[32*c+24 +: 8];
            o[32*c    +: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            o[32*c+8  +: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            o[32*c+16 +: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            o[32*c+24 +: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return o;
    endfunction

    // tap = state after ShiftRows of round 9, which is what decryption holds after E1.
    task automatic aes_enc(input logic [0:127] pt, input logic [0:1407] ks,
                           output logic [0:127] ct, output logic [0:127] tap);
        logic [0:127] s = pt ^ ks[0 +: 128];
        tap = '0;
        for (int r = 1; r <= 9; r++) begin
            s = sub_shift(s);
            if (r == 9) tap = s;
            s = mix(s) ^ ks[128*r +: 128];
        end
        ct = sub_shift(s) ^ ks[1280 +: 128];
    endtask

    task automatic do_run(input string tag, input logic [0:127] ct, input logic [0:127] pt,
                          input logic [0:1407] ks, input bit inject);
        logic [0:127] ct_m, tap;
        aes_enc(pt, ks, ct_m, tap);
        words = ks;
        ct_in = ct;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, " busy@E0"}, 128'(busy), 128'(1'b1));
        chk({tag, " ov@E0"}, 128'(out_valid), 128'(1'b0));
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
`ifdef INV_CIPHER_ROUND_TAP_EN
            if (e == 1) begin
                chk({tag, " round_state@E1"}, round_state, tap);
                chk({tag, " round_idx@E1"}, 128'(round_idx), 128'(4'd8));
            end
`endif
            if (inject && e == 3) begin
                start = 1'b1;
                ct_in = ~ct;
            end
            if (inject && e == 4) start = 1'b0;
            if (e < 10) begin
                chk({tag, " busy"}, 128'(busy), 128'(1'b1));
                chk({tag, " ov early"}, 128'(out_valid), 128'(1'b0));
            end
        end
        chk({tag, " ov@E10"}, 128'(out_valid), 128'(1'b1));
        chk({tag, " busy@E10"}, 128'(busy), 128'(1'b0));
        chk({tag, " out"}, out, pt);
    endtask

    localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    initial begin
        logic [0:1407] c1_ks, b_ks, r_ks;
        logic [0:127]  r_key, r_pt, r_ct, r_tap;

        rst_n = 1'b0;
        start = 1'b0;
        ct_in = '0;
        words = '0;
        build_sbox();
        c1_ks = expand(C1_KEY);
        b_ks  = expand(B_KEY);

        #12;
        chk("reset out", out, 128'h0);
        chk("reset out_valid", 128'(out_valid), 128'(1'b0));
        chk("reset busy", 128'(busy), 128'(1'b0));
        rst_n = 1'b1;

        do_run("C1", C1_CT, C1_PT, c1_ks, 1'b0);
        do_run("B", B_CT, B_PT, b_ks, 1'b0);
        do_run("C1 start-in-round", C1_CT, C1_PT, c1_ks, 1'b1);

        // Back-to-back with start held high: C.1 then B, second result at E21.
        words = c1_ks;
        ct_in = C1_CT;
        start = 1'b1;
        @(posedge clk); #1;
        ct_in = B_CT;
        repeat (9) @(posedge clk);
        #1 chk("b2b ov@E9", 128'(out_valid), 128'(1'b0));
        @(posedge clk); #1;
        chk("b2b ov@E10", 128'(out_valid), 128'(1'b1));
        chk("b2b out1", out, C1_PT);
        words = b_ks;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b ov@E11", 128'(out_valid), 128'(1'b0));
        chk("b2b busy@E11", 128'(busy), 128'(1'b1));
        chk("b2b out held@E11", out, C1_PT);
        repeat (9) @(posedge clk);
        #1 chk("b2b ov@E20", 128'(out_valid), 128'(1'b0));
        @(posedge clk); #1;
        chk("b2b ov@E21", 128'(out_valid), 128'(1'b1));
        chk("b2b out2", out, B_PT);

        // Asynchronous reset in the middle of a block.
        words = c1_ks;
        ct_in = C1_CT;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst out", out, 128'h0);
        chk("midrst out_valid", 128'(out_valid), 128'(1'b0));
        chk("midrst busy", 128'(busy), 128'(1'b0));
        #2 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1 chk("midrst no ov", 128'(out_valid), 128'(1'b0));
        do_run("C1 after reset", C1_CT, C1_PT, c1_ks, 1'b0);

        for (int n = 0; n < 100; n++) begin
            r_key = {$urandom(), $urandom(), $urandom(), $urandom()};
            r_pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            r_ks  = expand(r_key);
            aes_enc(r_pt, r_ks, r_ct, r_tap);
            do_run("loopback", r_ct, r_pt, r_ks, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
